spike_frame_loader: RTL and testbench
=====================================

Name: spike_frame_loader

Overview:
- Byte-serial command/payload loader for the spike-processing datapath.
- Assembles parametrised multi-channel sample frames from an 8-bit input stream.
- Also loads per-channel thresholds and classifier parameters at runtime, replacing hard-wired constants.
- Sits between the pad-level byte inputs and processing_system. Registers update atomically only on complete, error-free packets.

Parameters:
- NUM_CH, 4, number of channels.
- SAMPLE_W, 16, bits per sample/threshold; must be a multiple of 8.
- GAP_MAX, 15, max idle cycles allowed between payload bytes before abort.
- THRESH_RST, 16'h00C8, reset value of every channel threshold.
- CLASS_A_RST, 8'd20, reset class-A threshold.
- CLASS_B_RST, 8'd40, reset class-B threshold.
- TIMEOUT_RST, 16'd100, reset timeout period.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in valid this cycle
- frame_out  out  NUM_CH*SAMPLE_W  committed sample frame, channel 0 in LSBs
- frame_valid  out  1  one-cycle pulse on frame commit
- thresh_out  out  NUM_CH*SAMPLE_W  committed thresholds, channel 0 in LSBs
- class_a_out  out  8  class-A threshold
- class_b_out  out  8  class-B threshold
- timeout_out  out  16  timeout period
- cfg_valid  out  1  one-cycle pulse on threshold/param commit
- busy  out  1  high while a packet is in progress
- err  out  1  sticky error flag

Behaviour:
- Reset (async, rst=1):
  - frame_out=0; thresh_out=all channels THRESH_RST.
  - class_a_out=CLASS_A_RST, class_b_out=CLASS_B_RST, timeout_out=TIMEOUT_RST.
  - frame_valid=0, cfg_valid=0, busy=0, err=0; state IDLE.
- Header decoding: a byte accepted in IDLE is a header. Opcode is byte_in[7:6]; bits [5:0] are ignored.
  - 00 = NOP: clears err, stays IDLE.
  - 01 = DATA: payload is FB = NUM_CH*SAMPLE_W/8 bytes.
  - 10 = THRESH: payload is FB bytes.
  - 11 = PARAM: payload is 4 bytes: class_a, class_b, timeout[15:8], timeout[7:0].
- States and transitions:
  - IDLE -> PAYLOAD on a non-NOP header; busy=1 from the next cycle.
  - PAYLOAD accepts one byte per cycle with byte_valid=1.
  - DATA/THRESH bytes are little-endian, channel 0 first: byte k goes to shadow bits [8k+7:8k].
  - Bytes go into a shadow register; committed outputs never change mid-packet.
  - At the clock edge accepting the final payload byte: the shadow (including that byte) copies to its target, the matching pulse goes high for exactly the following cycle, busy drops, state returns to IDLE.
  - Latency: outputs and pulse are visible 1 cycle after the last byte is sampled.
  - Back-to-back: a header may arrive the cycle right after the last payload byte; the pulse and new busy overlap correctly.
- Gap timeout:
  - Gap counter resets on each accepted payload byte and increments on each PAYLOAD cycle with byte_valid=0.
  - When it reaches GAP_MAX+1: abort, err=1, busy=0, IDLE, shadow discarded, no commit, no pulse.
- err behaviour: sticky, cleared only by a NOP header or reset. Packets are still processed while err=1.
- Shadow reset: the shadow clears at every header, so a partial packet never leaks into the next.
- Reset mid-packet: immediate return to reset values; no pulse.
- Widths:
  - Byte counter is clog2(FB+1) bits; gap counter is clog2(GAP_MAX+2) bits. Neither wraps: the gap counter saturates at abort, and the byte counter clears at commit/abort.
  - If SAMPLE_W is not a multiple of 8: generate-time $error.

Optional Feature:
- Macro: SFL_CHECKSUM_EN.
- Defined: each DATA/THRESH/PARAM packet carries one extra trailing byte equal to the XOR of all payload bytes.
  - The commit happens on the edge accepting the checksum byte if it matches.
  - On mismatch: discard, err=1, no pulse, IDLE.
  - The gap rule applies to the checksum byte as well.
- Undefined: no checksum byte; commit on the last payload byte; no checksum logic is synthesised.

Test Plan (defaults, checksum off unless stated):
- Reset -> thresh_out=64'h00C8_00C8_00C8_00C8, class_a=20, class_b=40, timeout=100, frame_out=0, busy=0, err=0, no pulses.
- Header 0x40, bytes 01..08 on consecutive cycles -> frame_valid high exactly 1 cycle, frame_out=64'h0807_0605_0403_0201, busy low same cycle; no cfg_valid.
- Header 0x80, bytes 10,00,20,00,30,00,40,00 with 5-cycle gaps (<GAP_MAX) -> thresh_out=64'h0040_0030_0020_0010, cfg_valid 1 cycle, err=0.
- Header 0xC0, bytes 0A,1E,01,F4 -> class_a=10, class_b=30, timeout=500, cfg_valid 1 cycle.
- Header 0x40, 3 bytes, then 16 idle cycles -> err=1, busy=0, frame_out unchanged, no frame_valid; then header 0x00 -> err=0.
- Header 0x40 plus 4 bytes, then assert rst -> all outputs at reset values immediately. With SFL_CHECKSUM_EN: DATA 01..08 plus checksum 0x08 -> commit; checksum 0x09 -> err=1, no commit.

Source files
------------

// File: rtl/spike_frame_loader.sv
// Byte-serial loader: assembles sample frames, thresholds and classifier params from an 8-bit stream.
// Optional trailing XOR checksum byte per packet when SFL_CHECKSUM_EN is defined.
module spike_frame_loader #(
  parameter int                   NUM_CH      = 4,
  parameter int                   SAMPLE_W    = 16,
  parameter int                   GAP_MAX     = 15,
  parameter logic [SAMPLE_W-1:0]  THRESH_RST  = 16'h00C8,
  parameter logic [7:0]           CLASS_A_RST = 8'd20,
  parameter logic [7:0]           CLASS_B_RST = 8'd40,
  parameter logic [15:0]          TIMEOUT_RST = 16'd100
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [7:0]                   byte_in,
  input  logic                         byte_valid,
  output logic [NUM_CH*SAMPLE_W-1:0]   frame_out,
  output logic                         frame_valid,
  output logic [NUM_CH*SAMPLE_W-1:0]   thresh_out,
  output logic [7:0]                   class_a_out,
  output logic [7:0]                   class_b_out,
  output logic [15:0]                  timeout_out,
  output logic                         cfg_valid,
  output logic                         busy,
  output logic                         err
);

  localparam int FW      = NUM_CH * SAMPLE_W;
  localparam int FB      = FW / 8;
  localparam int LEN_MAX = (FB > 4) ? FB : 4;
`ifdef SFL_CHECKSUM_EN
  localparam int EXTRA   = 1;
`else
  localparam int EXTRA   = 0;
`endif
  localparam int CNT_W   = $clog2(LEN_MAX + EXTRA + 1);
  localparam int GAP_W   = $clog2(GAP_MAX + 2);
  localparam int SH_W    = LEN_MAX * 8;

  localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(FB + EXTRA - 1);
  localparam logic [CNT_W-1:0] PARAM_LAST = CNT_W'(4 + EXTRA - 1);

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_DATA   = 2'b01;
  localparam logic [1:0] OP_THRESH = 2'b10;
  localparam logic [1:0] OP_PARAM  = 2'b11;

  if ((SAMPLE_W % 8) != 0) begin : g_width_check
    $error("spike_frame_loader: SAMPLE_W must be a multiple of 8");
  end

  typedef enum logic {S_IDLE = 1'b0, S_PAYLOAD = 1'b1} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [SH_W-1:0]    r_shadow;
  logic [SH_W-1:0]    w_shadow_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_last_idx;
  logic [GAP_W-1:0]   r_gap;
  logic [1:0]         r_op;
  logic               r_err;
  logic [FW-1:0]      r_frame;
  logic [FW-1:0]      r_thresh;
  logic [7:0]         r_class_a;
  logic [7:0]         r_class_b;
  logic [15:0]        r_timeout;
  logic               r_frame_valid;
  logic               r_cfg_valid;
  logic               w_busy;
  logic               w_hdr;
  logic               w_accept;
  logic               w_final;
  logic               w_gap_abort;
  logic               w_sum_ok;

  assign w_hdr       = (r_state == S_IDLE) && byte_valid;
  assign w_accept    = (r_state == S_PAYLOAD) && byte_valid;
  assign w_last_idx  = (r_op == OP_PARAM) ? PARAM_LAST : DATA_LAST;
  assign w_final     = w_accept && (r_cnt == w_last_idx);
  assign w_gap_abort = (r_state == S_PAYLOAD) && !byte_valid && (r_gap == GAP_W'(GAP_MAX));

`ifdef SFL_CHECKSUM_EN
  logic [7:0] r_xor;

  // running XOR of payload bytes, restarted at each header
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_xor <= 8'h00;
    end else if (w_hdr) begin
      r_xor <= 8'h00;
    end else if (w_accept) begin
      r_xor <= r_xor ^ byte_in;
    end
  end

  assign w_sum_ok = (byte_in == r_xor);
`else
  assign w_sum_ok = 1'b1;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (byte_valid && (byte_in[7:6] != OP_NOP)) w_state_next = S_PAYLOAD;
        else                                        w_state_next = S_IDLE;
      end
      S_PAYLOAD: begin
        if (w_final || w_gap_abort) w_state_next = S_IDLE;
        else                        w_state_next = S_PAYLOAD;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // state-decoded outputs
  always_comb begin
    w_busy = 1'b0;
    case (r_state)
      S_IDLE:    w_busy = 1'b0;
      S_PAYLOAD: w_busy = 1'b1;
      default:   w_busy = 1'b0;
    endcase
  end

  // shadow with the current byte merged in, so commit sees the final byte too
  always_comb begin
    w_shadow_next = r_shadow;
    for (int k = 0; k < LEN_MAX; k++) begin
      if (r_cnt == CNT_W'(k)) w_shadow_next[8*k +: 8] = byte_in;
      else                    w_shadow_next[8*k +: 8] = r_shadow[8*k +: 8];
    end
  end

  // packet assembly, gap timeout, atomic commit and error tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_shadow      <= '0;
      r_cnt         <= '0;
      r_gap         <= '0;
      r_op          <= OP_NOP;
      r_err         <= 1'b0;
      r_frame       <= '0;
      r_thresh      <= {NUM_CH{THRESH_RST}};
      r_class_a     <= CLASS_A_RST;
      r_class_b     <= CLASS_B_RST;
      r_timeout     <= TIMEOUT_RST;
      r_frame_valid <= 1'b0;
      r_cfg_valid   <= 1'b0;
    end else begin
      r_frame_valid <= 1'b0;
      r_cfg_valid   <= 1'b0;
      if (w_hdr) begin
        r_shadow <= '0;
        r_cnt    <= '0;
        r_gap    <= '0;
        r_op     <= byte_in[7:6];
        if (byte_in[7:6] == OP_NOP) r_err <= 1'b0;
      end else if (w_accept) begin
        r_shadow <= w_shadow_next;
        r_gap    <= '0;
        if (w_final) begin
          r_cnt <= '0;
          if (w_sum_ok) begin
            case (r_op)
              OP_DATA: begin
                r_frame       <= w_shadow_next[FW-1:0];
                r_frame_valid <= 1'b1;
              end
              OP_THRESH: begin
                r_thresh    <= w_shadow_next[FW-1:0];
                r_cfg_valid <= 1'b1;
              end
              OP_PARAM: begin
                r_class_a   <= w_shadow_next[7:0];
                r_class_b   <= w_shadow_next[15:8];
                r_timeout   <= {w_shadow_next[23:16], w_shadow_next[31:24]};
                r_cfg_valid <= 1'b1;
              end
              default: r_cfg_valid <= 1'b0;
            endcase
          end else begin
            r_err <= 1'b1;
          end
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else if (w_gap_abort) begin
        r_shadow <= '0;
        r_cnt    <= '0;
        r_gap    <= GAP_W'(GAP_MAX + 1);
        r_err    <= 1'b1;
      end else if (r_state == S_PAYLOAD) begin
        r_gap <= r_gap + GAP_W'(1);
      end
    end
  end

  assign frame_out   = r_frame;
  assign frame_valid = r_frame_valid;
  assign thresh_out  = r_thresh;
  assign class_a_out = r_class_a;
  assign class_b_out = r_class_b;
  assign timeout_out = r_timeout;
  assign cfg_valid   = r_cfg_valid;
  assign busy        = w_busy;
  assign err         = r_err;

endmodule

// File: tb/tb_spike_frame_loader.sv
// Directed self-checking bench for spike_frame_loader (default parameters).
module tb_spike_frame_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic [63:0] frame_out;
  logic        frame_valid;
  logic [63:0] thresh_out;
  logic [7:0]  class_a_out;
  logic [7:0]  class_b_out;
  logic [15:0] timeout_out;
  logic        cfg_valid;
  logic        busy;
  logic        err;

  spike_frame_loader dut (
    .clk         (clk),
    .rst         (rst),
    .byte_in     (byte_in),
    .byte_valid  (byte_valid),
    .frame_out   (frame_out),
    .frame_valid (frame_valid),
    .thresh_out  (thresh_out),
    .class_a_out (class_a_out),
    .class_b_out (class_b_out),
    .timeout_out (timeout_out),
    .cfg_valid   (cfg_valid),
    .busy        (busy),
    .err         (err)
  );

  always #5 clk = ~clk;

  localparam logic [63:0] THR_RST = 64'h00C8_00C8_00C8_00C8;
  localparam logic [63:0] FRAME1  = 64'h0807_0605_0403_0201;
  localparam logic [63:0] THR_NEW = 64'h0040_0030_0020_0010;

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        fv;
    logic        cv;
    logic        bsy;
    logic        er;
    logic [63:0] frame;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h, expected %h", nm, act, exp);
    else             n_pass++;
  endtask

  task automatic step(input logic v, input logic [7:0] d);
    byte_valid = v;
    byte_in    = d;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic fv, input logic cv,
                     input logic b, input logic e, input logic [63:0] f);
    vec_t x;
    x.v = v; x.d = d; x.fv = fv; x.cv = cv; x.bsy = b; x.er = e; x.frame = f;
    vq.push_back(x);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_frame"},   frame_out,   64'h0);
    chk({tag, "_thresh"},  thresh_out,  THR_RST);
    chk({tag, "_class_a"}, class_a_out, 64'd20);
    chk({tag, "_class_b"}, class_b_out, 64'd40);
    chk({tag, "_timeout"}, timeout_out, 64'd100);
    chk({tag, "_busy"},    busy,        64'd0);
    chk({tag, "_err"},     err,         64'd0);
    chk({tag, "_fv"},      frame_valid, 64'd0);
    chk({tag, "_cv"},      cfg_valid,   64'd0);
  endtask

  logic [7:0] thr_bytes [8];

  initial begin
    rst        = 1'b1;
    byte_valid = 1'b0;
    byte_in    = 8'h00;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst_held");
    rst = 1'b0;
    @(negedge clk);
    chk_reset_vals("rst_rel");

    // DATA packet, then PARAM header back-to-back in the frame_valid cycle
    add(1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    for (int k = 1; k < 8; k++) add(1'b1, 8'(k), 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
`ifdef SFL_CHECKSUM_EN
    add(1'b1, 8'h08, 1'b0, 1'b0, 1'b1, 1'b0, 64'h0);
    add(1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, FRAME1);
`else
    add(1'b1, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, FRAME1);
`endif
    add(1'b1, 8'hC0, 1'b0, 1'b0, 1'b1, 1'b0, FRAME1);
    add(1'b1, 8'h0A, 1'b0, 1'b0, 1'b1, 1'b0, FRAME1);
    add(1'b1, 8'h1E, 1'b0, 1'b0, 1'b1, 1'b0, FRAME1);
    add(1'b1, 8'h01, 1'b0, 1'b0, 1'b1, 1'b0, FRAME1);
`ifdef SFL_CHECKSUM_EN
    add(1'b1, 8'hF4, 1'b0, 1'b0, 1'b1, 1'b0, FRAME1);
    add(1'b1, 8'hE1, 1'b0, 1'b1, 1'b0, 1'b0, FRAME1);
`else
    add(1'b1, 8'hF4, 1'b0, 1'b1, 1'b0, 1'b0, FRAME1);
`endif
    add(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, FRAME1);

    for (int i = 0; i < vq.size(); i++) begin
      step(vq[i].v, vq[i].d);
      chk($sformatf("vec%0d_fv", i),    frame_valid, vq[i].fv);
      chk($sformatf("vec%0d_cv", i),    cfg_valid,   vq[i].cv);
      chk($sformatf("vec%0d_busy", i),  busy,        vq[i].bsy);
      chk($sformatf("vec%0d_err", i),   err,         vq[i].er);
      chk($sformatf("vec%0d_frame", i), frame_out,   vq[i].frame);
    end
    chk("param_class_a", class_a_out, 64'd10);
    chk("param_class_b", class_b_out, 64'd30);
    chk("param_timeout", timeout_out, 64'd500);
    chk("param_thresh_kept", thresh_out, THR_RST);

    // THRESH packet with 5 idle cycles before every byte
    thr_bytes = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00};
    step(1'b1, 8'h80);
    for (int i = 0; i < 8; i++) begin
      repeat (5) step(1'b0, 8'h00);
      step(1'b1, thr_bytes[i]);
      if (i == 6) begin
        chk("thr_mid_thresh", thresh_out, THR_RST);
        chk("thr_mid_busy",   busy,       64'd1);
        chk("thr_mid_cv",     cfg_valid,  64'd0);
      end
    end
`ifdef SFL_CHECKSUM_EN
    repeat (5) step(1'b0, 8'h00);
    step(1'b1, 8'h40);
`endif
    chk("thr_cv",     cfg_valid,   64'd1);
    chk("thr_val",    thresh_out,  THR_NEW);
    chk("thr_err",    err,         64'd0);
    chk("thr_busy",   busy,        64'd0);
    chk("thr_fv",     frame_valid, 64'd0);
    step(1'b0, 8'h00);
    chk("thr_cv_drop", cfg_valid,  64'd0);

    // gap abort: 15 idle cycles tolerated, the 16th aborts
    step(1'b1, 8'h40);
    step(1'b1, 8'h11);
    step(1'b1, 8'h22);
    step(1'b1, 8'h33);
    repeat (15) step(1'b0, 8'h00);
    chk("gap15_busy", busy, 64'd1);
    chk("gap15_err",  err,  64'd0);
    step(1'b0, 8'h00);
    chk("gap16_err",   err,         64'd1);
    chk("gap16_busy",  busy,        64'd0);
    chk("gap16_fv",    frame_valid, 64'd0);
    chk("gap16_frame", frame_out,   FRAME1);
    step(1'b0, 8'h00);
    chk("gap_err_sticky", err,         64'd1);
    chk("gap_fv_after",   frame_valid, 64'd0);
    step(1'b1, 8'h00);
    chk("nop_err_clr", err,  64'd0);
    chk("nop_busy",    busy, 64'd0);

`ifdef SFL_CHECKSUM_EN
    // bad checksum (correct value would be 0x08)
    step(1'b1, 8'h40);
    for (int k = 1; k < 9; k++) step(1'b1, 8'(8'h10 + k));
    step(1'b1, 8'h09);
    chk("cks_bad_err",   err,         64'd1);
    chk("cks_bad_fv",    frame_valid, 64'd0);
    chk("cks_bad_busy",  busy,        64'd0);
    chk("cks_bad_frame", frame_out,   FRAME1);
    step(1'b1, 8'h00);
    chk("cks_nop_err", err, 64'd0);
`endif

    // asynchronous reset in the middle of a DATA packet
    step(1'b1, 8'h40);
    step(1'b1, 8'hAA);
    step(1'b1, 8'hBB);
    step(1'b1, 8'hCC);
    step(1'b1, 8'hDD);
    chk("mid_busy", busy, 64'd1);
    byte_valid = 1'b0;
    #2 rst = 1'b1;
    #1 chk_reset_vals("mid_rst");
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, 8'h00);
    chk("post_rst_busy", busy,        64'd0);
    chk("post_rst_fv",   frame_valid, 64'd0);
    chk("post_rst_frame", frame_out,  64'h0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
